zoom_ctrl: RTL and testbench



---
 rtl/zoom_ctrl.sv | 161 ++++++++++++++++
 tb/tb_zoom_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/zoom_ctrl.sv
// -----------------------------------------------------------------------------
// zoom_ctrl
// Display-side controller for the frame-buffer scaler. It turns the VGA timing
// counters into read addresses for a 128x128 RGB332 frame buffer. The image
// sits in a fixed on-screen window and can be shown at 1x, 2x or 4x integer
// zoom. Two buttons step a pending zoom value, which becomes the displayed
// zoom only at frame start.
//
// Ports
//   ck        system clock (50 MHz)
//   rst_n     asynchronous active-low reset
//   pix_en    pixel-rate enable, high one ck in two
//   hcnt      horizontal counter from the timing generator
//   vcnt      vertical counter from the timing generator
//   btn_in    zoom-in button (asynchronous, debounced externally)
//   btn_out   zoom-out button (asynchronous, debounced externally)
//   fb_douta  frame-buffer read data, valid one ck after fb_addr
//   fb_addr   frame-buffer read address
//   outRed    red   (fb_douta[7:5])
//   outGreen  green (fb_douta[4:2])
//   outBlue   blue  (fb_douta[1:0])
//   zoom      committed zoom shift (0=1x, 1=2x, 2=4x)
// -----------------------------------------------------------------------------
module zoom_ctrl #(
  parameter int IMG_W    = 128,
  parameter int IMG_H    = 128,
  parameter int ADDR_W   = 15,
  parameter int X0       = 100,
  parameter int Y0       = 100,
  parameter int PAL      = 640,
  parameter int LAF      = 480,
  parameter int ZOOM_RST = 1
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [9:0]        hcnt,
  input  logic [9:0]        vcnt,
  input  logic              btn_in,
  input  logic              btn_out,
  input  logic [7:0]        fb_douta,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        outRed,
  output logic [2:0]        outGreen,
  output logic [1:0]        outBlue,
  output logic [1:0]        zoom
);

  localparam logic [1:0] ZOOM_MAX = 2'd2;

  // Button synchronizers and edge-detect history.
  logic [1:0] in_sync_q, out_sync_q;
  logic       in_prev_q, out_prev_q;
  logic       in_rise, out_rise;

  logic [1:0] pending_q, pending_d;
  logic [1:0] zoom_q;

  logic [ADDR_W-1:0] fb_addr_q;
  logic              valid_q;
  logic [7:0]        rgb_q;

  // ---------------------------------------------------------------------------
  // Buttons: run on every ck so that short presses are never lost while
  // pix_en is low.
  // ---------------------------------------------------------------------------
  assign in_rise  = in_sync_q[1]  & ~in_prev_q;
  assign out_rise = out_sync_q[1] & ~out_prev_q;

  always_comb begin
    // NOTE: default assignment first so every path drives pending_d; a missing
    // branch would otherwise infer a latch.
    pending_d = pending_q;
    if (in_rise && !out_rise) begin
      if (pending_q != ZOOM_MAX) pending_d = pending_q + 2'd1;
    end else if (out_rise && !in_rise) begin
      if (pending_q != 2'd0) pending_d = pending_q - 2'd1;
    end
  end

  // NOTE: every register here, including the button history, gets a reset
  // value; there is no array-style storage that would justify leaving one out.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      in_sync_q  <= '0;
      out_sync_q <= '0;
      in_prev_q  <= 1'b0;
      out_prev_q <= 1'b0;
      pending_q  <= 2'(ZOOM_RST);
    end else begin
      // NOTE: non-blocking assignments so each stage samples the previous
      // stage's old value, giving a true two-flop chain.
      in_sync_q  <= {in_sync_q[0], btn_in};
      out_sync_q <= {out_sync_q[0], btn_out};
      in_prev_q  <= in_sync_q[1];
      out_prev_q <= out_sync_q[1];
      pending_q  <= pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame commit. zoom takes the pending value held before this ck, so a button
  // edge landing on the commit ck only shows up in the next frame.
  // ---------------------------------------------------------------------------
  logic frame_start;
  assign frame_start = pix_en && (hcnt == 10'd0) && (vcnt == 10'd0);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) zoom_q <= 2'(ZOOM_RST);
    else if (frame_start) zoom_q <= pending_q;
  end

  // ---------------------------------------------------------------------------
  // Window decode. Comparisons are done at 12 bits so the 4x window end
  // (X0 + 512) cannot overflow the 10-bit counters.
  // ---------------------------------------------------------------------------
  logic [11:0] h_ext, v_ext, h_end, v_end;
  logic        in_win;

  assign h_ext = {2'b00, hcnt};
  assign v_ext = {2'b00, vcnt};
  assign h_end = 12'(X0) + (12'(IMG_W) << zoom_q);
  assign v_end = 12'(Y0) + (12'(IMG_H) << zoom_q);

  assign in_win = (h_ext >= 12'(X0)) && (h_ext < h_end) && (h_ext < 12'(PAL)) &&
                  (v_ext >= 12'(Y0)) && (v_ext < v_end) && (v_ext < 12'(LAF));

  // Image coordinates: window offset divided by the zoom factor. Only
  // meaningful when in_win is set, where both results are below IMG_W/IMG_H.
  logic [9:0]        h_off, v_off, dx, dy;
  logic [ADDR_W-1:0] addr_calc;

  assign h_off     = hcnt - 10'(X0);
  assign v_off     = vcnt - 10'(Y0);
  assign dx        = h_off >> zoom_q;
  assign dy        = v_off >> zoom_q;
  assign addr_calc = ADDR_W'(32'(dy) * 32'(IMG_W) + 32'(dx));

  // ---------------------------------------------------------------------------
  // One-pixel pipeline: address and valid flag on one pix_en, the returned
  // data lands on the RGB outputs at the following pix_en.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      fb_addr_q <= '0;
      valid_q   <= 1'b0;
      rgb_q     <= '0;
    end else if (pix_en) begin
      if (in_win) fb_addr_q <= addr_calc;
      valid_q <= in_win;
      rgb_q   <= valid_q ? fb_douta : 8'h00;
    end
  end

  assign fb_addr  = fb_addr_q;
  assign outRed   = rgb_q[7:5];
  assign outGreen = rgb_q[4:2];
  assign outBlue  = rgb_q[1:0];
  assign zoom     = zoom_q;

endmodule

// File: tb/tb_zoom_ctrl.sv
// -----------------------------------------------------------------------------
// tb_zoom_ctrl
// Directed bench for zoom_ctrl. Pixels are applied one at a time (pix_en high
// for one ck, low for the next), jumping straight to the coordinates of
// interest. The frame-buffer model returns the low byte of the address one ck
// after it is presented, so RGB values can be predicted by hand.
// -----------------------------------------------------------------------------
module tb_zoom_ctrl;

  logic        ck = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  hcnt = '0;
  logic [9:0]  vcnt = '0;
  logic        btn_in = 1'b0;
  logic        btn_out = 1'b0;
  logic [7:0]  fb_douta;
  logic [14:0] fb_addr;
  logic [2:0]  outRed, outGreen;
  logic [1:0]  outBlue;
  logic [1:0]  zoom;

  int checks = 0;
  int errors = 0;

  zoom_ctrl dut (
    .ck       (ck),
    .rst_n    (rst_n),
    .pix_en   (pix_en),
    .hcnt     (hcnt),
    .vcnt     (vcnt),
    .btn_in   (btn_in),
    .btn_out  (btn_out),
    .fb_douta (fb_douta),
    .fb_addr  (fb_addr),
    .outRed   (outRed),
    .outGreen (outGreen),
    .outBlue  (outBlue),
    .zoom     (zoom)
  );

  always #10 ck = ~ck;

  // Frame-buffer model: synchronous read returning addr[7:0].
  always @(posedge ck) fb_douta <= fb_addr[7:0];

  logic [7:0] rgb;
  assign rgb = {outRed, outGreen, outBlue};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pixel: pix_en high for one ck at (h,v), then one idle ck.
  task automatic pixel(input int h, input int v);
    @(negedge ck);
    hcnt   = 10'(h);
    vcnt   = 10'(v);
    pix_en = 1'b1;
    @(negedge ck);
    pix_en = 1'b0;
  endtask

  task automatic press(input logic i, input logic o);
    @(negedge ck);
    btn_in  = i;
    btn_out = o;
    repeat (4) @(negedge ck);
    btn_in  = 1'b0;
    btn_out = 1'b0;
    repeat (4) @(negedge ck);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge ck);
    check("rst_zoom", 32'(zoom), 1);
    check("rst_addr", 32'(fb_addr), 0);
    check("rst_rgb", 32'(rgb), 0);
    rst_n = 1'b1;

    // 2x addressing and window edge
    pixel(101, 103);
    check("addr_101_103", 32'(fb_addr), 128);
    pixel(355, 355);
    check("addr_355_355", 32'(fb_addr), 16383);
    check("rgb_after_101_103", 32'(rgb), 8'h80);
    pixel(356, 200);
    check("addr_hold_356", 32'(fb_addr), 16383);
    check("rgb_after_355", 32'(rgb), 8'hFF);
    pixel(357, 200);
    check("rgb_black_356", 32'(rgb), 0);

    // 2x replication
    pixel(100, 100); check("rep_100_100", 32'(fb_addr), 0);
    pixel(101, 100); check("rep_101_100", 32'(fb_addr), 0);
    pixel(100, 101); check("rep_100_101", 32'(fb_addr), 0);
    pixel(101, 101); check("rep_101_101", 32'(fb_addr), 0);
    check("rep_rgb0", 32'(rgb), 0);
    pixel(102, 100); check("rep_102_100", 32'(fb_addr), 1);
    pixel(103, 100); check("rep_103_100", 32'(fb_addr), 1);
    check("rep_rgb1", 32'(rgb), 1);
    pixel(200, 150); check("addr_200_150", 32'(fb_addr), 3250);
    pixel(202, 150); check("addr_202_150", 32'(fb_addr), 3251);
    check("rgb_200_150", 32'(rgb), 8'hB2);

    // Zoom-in mid-frame is deferred to frame start
    pixel(150, 200);
    press(1'b1, 1'b0);
    check("zoom_deferred", 32'(zoom), 1);
    pixel(300, 300);
    check("addr_still_2x", 32'(fb_addr), 12900);
    pixel(0, 0);
    check("zoom_commit_4x", 32'(zoom), 2);
    pixel(103, 100); check("4x_103_100", 32'(fb_addr), 0);
    pixel(104, 100); check("4x_104_100", 32'(fb_addr), 1);
    pixel(150, 479); check("4x_line479", 32'(fb_addr), 12044);
    pixel(151, 479); check("4x_rgb479", 32'(rgb), 8'h0C);
    pixel(150, 480); check("4x_line480_hold", 32'(fb_addr), 12044);
    pixel(151, 480); check("4x_line480_black", 32'(rgb), 0);

    // Saturation
    repeat (4) press(1'b0, 1'b1);
    pixel(0, 0); check("sat_low", 32'(zoom), 0);
    repeat (3) press(1'b1, 1'b0);
    pixel(0, 0); check("sat_high", 32'(zoom), 2);
    repeat (4) press(1'b0, 1'b1);
    pixel(0, 0); check("sat_low2", 32'(zoom), 0);
    pixel(227, 227); check("1x_227_227", 32'(fb_addr), 16383);
    pixel(228, 100); check("1x_228_hold", 32'(fb_addr), 16383);
    check("1x_rgb_227", 32'(rgb), 8'hFF);
    pixel(229, 100); check("1x_228_black", 32'(rgb), 0);

    // Simultaneous edges leave pending unchanged
    press(1'b1, 1'b0);
    pixel(0, 0); check("zoom_to_1", 32'(zoom), 1);
    press(1'b1, 1'b1);
    pixel(0, 0); check("both_ignored", 32'(zoom), 1);

    // Blanking
    pixel(150, 150); check("addr_150_150", 32'(fb_addr), 3225);
    pixel(640, 150); check("rgb_150_150", 32'(rgb), 8'h99);
    for (int h = 641; h < 800; h++) begin
      pixel(h, 150);
      check("hblank_rgb", 32'(rgb), 0);
      check("hblank_addr", 32'(fb_addr), 3225);
    end
    for (int v = 480; v <= 520; v++) begin
      pixel(200, v);
      check("vblank_rgb", 32'(rgb), 0);
      check("vblank_addr", 32'(fb_addr), 3225);
    end

    // pix_en low freezes the pipeline
    pixel(200, 200); check("addr_200_200", 32'(fb_addr), 6450);
    pixel(202, 200); check("addr_202_200", 32'(fb_addr), 6451);
    check("rgb_200_200", 32'(rgb), 8'h32);
    @(negedge ck);
    hcnt = 10'd300;
    vcnt = 10'd210;
    repeat (10) @(negedge ck);
    check("freeze_addr", 32'(fb_addr), 6451);
    check("freeze_rgb", 32'(rgb), 8'h32);

    // Mid-frame reset
    press(1'b0, 1'b1);
    pixel(0, 0); check("zoom_to_0", 32'(zoom), 0);
    pixel(110, 120); check("addr_110_120", 32'(fb_addr), 2570);
    pixel(111, 120); check("rgb_110_120", 32'(rgb), 8'h0A);
    @(negedge ck);
    hcnt  = 10'd300;
    vcnt  = 10'd250;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rgb", 32'(rgb), 0);
    check("mid_rst_addr", 32'(fb_addr), 0);
    check("mid_rst_zoom", 32'(zoom), 1);
    repeat (3) @(negedge ck);
    rst_n = 1'b1;
    pixel(300, 250); check("resume_addr", 32'(fb_addr), 9700);
    pixel(302, 250); check("resume_rgb", 32'(rgb), 8'hE4);
    pixel(0, 0); check("resume_commit", 32'(zoom), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
